// File: rtl/ysyx_25060170_ifu_hs_if.sv
// ysyx_25060170_ifu_hs_if: instruction-memory bus, EXU redirect and IDU channel seen by the IFU
interface ysyx_25060170_ifu_hs_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic            imem_rsp_ready;
    logic [XLEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_fault;

    // IFU side
    modport master (
        output imem_req_valid, imem_req_addr, imem_rsp_ready,
        output out_valid, out_pc, out_inst, out_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  redirect_valid, redirect_pc, out_ready
    );

    // memory / EXU / IDU side
    modport slave (
        input  imem_req_valid, imem_req_addr, imem_rsp_ready,
        input  out_valid, out_pc, out_inst, out_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/ysyx_25060170_ifu_hs.sv
// ysyx_25060170_ifu_hs: handshaked instruction fetch unit, one fetch in flight, redirectable
module ysyx_25060170_ifu_hs #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ysyx_25060170_ifu_hs_if.master bus,
    output logic [CNT_W-1:0]       fetch_cnt
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d, inst_q, inst_d;
    logic              stale_q, stale_d, fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              redir, req_hs, rsp_hs, out_hs, tgt_mis, drop, load_mem, load_mis;

    assign redir   = bus.redirect_valid;
    assign req_hs  = state_q == S_REQ && bus.imem_req_ready;
    assign rsp_hs  = state_q == S_WAIT && bus.imem_rsp_valid;
    assign out_hs  = state_q == S_OUT && !redir && bus.out_ready;
    // Where the PC will point after this cycle is misaligned: such a target is
    // delivered as a fault straight from S_OUT instead of being fetched.
    assign tgt_mis = redir ? bus.redirect_pc[1:0] != 2'b00 : pc_q[1:0] != 2'b00;
    // A response is thrown away if a redirect happened after its request left.
    assign drop    = stale_q || redir;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_REQ;
        else        state_q <= state_d;
    end

    // Next state: redirects pre-empt everything; a stale response is drained first
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:   state_d = req_hs ? S_WAIT : (redir && tgt_mis) ? S_OUT : S_REQ;
            S_WAIT:  state_d = !rsp_hs ? S_WAIT : !drop ? S_OUT : tgt_mis ? S_OUT : S_REQ;
            S_OUT:   state_d = redir ? (tgt_mis ? S_OUT : S_REQ) : out_hs ? S_REQ : S_OUT;
            default: state_d = S_REQ;
        endcase
    end

    // Outputs: request/response handshake enables and the combinational redirect kill
    always_comb begin
        bus.imem_req_valid = rst_n && state_q == S_REQ;
        bus.imem_req_addr  = pc_q;
        bus.imem_rsp_ready = state_q == S_WAIT;
        bus.out_valid      = state_q == S_OUT && !redir;
        bus.out_pc         = pc_q;
        bus.out_inst       = inst_q;
        bus.out_fault      = fault_q;
        fetch_cnt          = cnt_q;
    end

    // Datapath next values: PC, stale flag, delivered word/fault and the handshake counter
    always_comb begin
        load_mem = rsp_hs && !drop;
        load_mis = state_d == S_OUT && drop;
        pc_d     = redir ? bus.redirect_pc : out_hs ? pc_q + XLEN'(4) : pc_q;
        stale_d  = rsp_hs ? 1'b0 : stale_q || (redir && (state_q == S_WAIT || req_hs));
        inst_d   = load_mis ? '0 : load_mem ? (bus.imem_rsp_err ? '0 : bus.imem_rsp_data) : inst_q;
        fault_d  = load_mis ? 1'b1 : load_mem ? bus.imem_rsp_err : fault_q;
        cnt_d    = cnt_q + CNT_W'(out_hs);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            stale_q <= 1'b0;
            inst_q  <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            stale_q <= stale_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ysyx_25060170_ifu_hs.sv
// tb_ysyx_25060170_ifu_hs: directed and random checks of the IFU against a PC/counter model and a memory model
module tb_ysyx_25060170_ifu_hs;
    localparam int          XLEN   = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] fetch_cnt;

    ysyx_25060170_ifu_hs_if #(.XLEN(XLEN)) bus ();
    ysyx_25060170_ifu_hs #(.XLEN(XLEN), .RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pc;
    logic        m_synth;
    int          m_cnt;
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_left;
    int          mem_delay = 0;
    logic        mem_rand = 1'b0;
    int          idle = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a == RST_PC ? 32'h0000_0413 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (int'(a[11:2]) % 11) == 5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model by the handshakes seen
    task automatic cycle(input logic rq_rdy, input logic o_rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        bus.imem_req_ready = rq_rdy;
        bus.out_ready      = o_rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_rsp_valid = mem_busy && mem_left == 0;
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_data(mem_addr) : 32'hDEAD_BEEF;
        bus.imem_rsp_err   = bus.imem_rsp_valid && mem_err(mem_addr);
        #1;
        chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt % 16));
        if (mem_busy) chk("rsp_ready", 32'(bus.imem_rsp_ready), 32'd1);
        if (bus.imem_req_valid) begin
            chk("req_addr", bus.imem_req_addr, m_pc);
            chk("req_unexpected", 32'(mem_busy || m_synth), 32'd0);
        end
        if (rv) chk("out_valid_killed", 32'(bus.out_valid), 32'd0);
        if (bus.out_valid) begin
            chk("out_pc", bus.out_pc, m_pc);
            chk("out_inst", bus.out_inst, (m_synth || mem_err(m_pc)) ? 32'd0 : mem_data(m_pc));
            chk("out_fault", 32'(bus.out_fault), 32'(m_synth || mem_err(m_pc)));
            idle = 0;
        end else if (++idle > 150) begin
            n_cmp++;
            n_bad++;
            $display("FAIL progress: got no out_valid for %0d cycles, required at most 150", idle);
            idle = 0;
        end
        if (bus.imem_rsp_valid && bus.imem_rsp_ready) mem_busy = 1'b0;
        else if (mem_busy && mem_left > 0) mem_left--;
        if (bus.imem_req_valid && rq_rdy) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_req_addr;
            mem_left = mem_rand ? int'($urandom_range(0, 3)) : mem_delay;
        end
        if (rv) begin
            m_pc    = rpc;
            m_synth = rpc[1:0] != 2'b00;
        end else if (bus.out_valid && o_rdy) begin
            m_pc    = m_pc + 32'd4;
            m_synth = 1'b0;
            m_cnt++;
        end
    endtask

    // Asynchronous reset of DUT, memory and model, released away from the clock edge
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_rsp_ready", 32'(bus.imem_rsp_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
        chk("rst_pc", bus.out_pc, 32'h8000_0000);
        @(negedge clk);
        rst_n    = 1'b1;
        m_pc     = RST_PC;
        m_synth  = 1'b0;
        m_cnt    = 0;
        mem_busy = 1'b0;
        mem_left = 0;
        idle     = 0;
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.imem_rsp_err   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b0;
        do_reset();

        // zero-wait memory: request n, response n+1, out_valid n+2, next request n+3
        mem_delay = 0;
        cycle(1, 1, 0, 0);
        chk("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t1_req_addr", bus.imem_req_addr, 32'h8000_0000);
        cycle(1, 1, 0, 0);
        chk("t1_no_out_yet", 32'(bus.out_valid), 32'd0);
        cycle(1, 1, 0, 0);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_out_pc", bus.out_pc, 32'h8000_0000);
        chk("t1_out_inst", bus.out_inst, 32'h0000_0413);
        cycle(0, 1, 0, 0);
        chk("t1_next_req", bus.imem_req_addr, 32'h8000_0004);
        chk("t1_cnt", 32'(fetch_cnt), 32'd1);

        // request stalled 3 cycles, response 4 cycles after acceptance, IDU stalls 5 cycles
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 0);
            chk("t2_addr_stable", bus.imem_req_addr, 32'h8000_0004);
        end
        mem_delay = 3;
        cycle(1, 0, 0, 0);
        chk("t2_req_valid", 32'(bus.imem_req_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            chk("t2_no_out", 32'(bus.out_valid), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0);
            chk("t2_out_held", 32'(bus.out_valid), 32'd1);
            chk("t2_out_pc", bus.out_pc, 32'h8000_0004);
            chk("t2_out_inst", bus.out_inst, mem_data(32'h8000_0004));
        end
        cycle(0, 1, 0, 0);
        chk("t2_out_hs", 32'(bus.out_valid), 32'd1);
        cycle(0, 1, 0, 0);
        chk("t2_cnt", 32'(fetch_cnt), 32'd2);
        chk("t2_next_req", bus.imem_req_addr, 32'h8000_0008);

        // redirect while waiting: stale response discarded
        mem_delay = 1;
        cycle(1, 1, 0, 0);
        cycle(0, 1, 1, 32'h8000_0100);
        chk("t3_out_low_a", 32'(bus.out_valid), 32'd0);
        cycle(0, 1, 0, 0);
        chk("t3_out_low_b", 32'(bus.out_valid), 32'd0);
        cycle(0, 1, 0, 0);
        chk("t3_out_low_c", 32'(bus.out_valid), 32'd0);
        chk("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t3_req_addr", bus.imem_req_addr, 32'h8000_0100);

        // redirect in S_OUT together with out_ready: no delivery, no count
        mem_delay = 0;
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 32'h8000_0200);
        chk("t4_out_killed", 32'(bus.out_valid), 32'd0);
        cycle(0, 1, 0, 0);
        chk("t4_cnt", 32'(fetch_cnt), 32'd2);
        chk("t4_req_addr", bus.imem_req_addr, 32'h8000_0200);

        // misaligned redirect: fault delivered without a memory request
        cycle(0, 1, 1, 32'h8000_0102);
        cycle(0, 0, 0, 0);
        chk("t5_no_req", 32'(bus.imem_req_valid), 32'd0);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t5_out_pc", bus.out_pc, 32'h8000_0102);
        chk("t5_out_fault", 32'(bus.out_fault), 32'd1);
        chk("t5_out_inst", bus.out_inst, 32'd0);
        cycle(0, 1, 0, 0);

        // memory access error
        cycle(0, 1, 1, 32'h8000_0014);
        cycle(1, 1, 0, 0);
        chk("t6_req_addr", bus.imem_req_addr, 32'h8000_0014);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("t6_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_out_fault", 32'(bus.out_fault), 32'd1);
        chk("t6_out_inst", bus.out_inst, 32'd0);

        // random traffic with a reset in the middle
        mem_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            if (i == 1500) do_reset();
            rpc = 32'h8000_0000 | ($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 3) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc);
        end

        // counter wrap: 16 deliveries on a 4-bit counter read back 0
        do_reset();
        mem_rand  = 1'b0;
        mem_delay = 0;
        repeat (48) cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("wrap_cnt", 32'(fetch_cnt), 32'd0);
        chk("wrap_req_addr", bus.imem_req_addr, 32'h8000_0040);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ysyx_25060170_ifu_hs.md
# ysyx_25060170_ifu_hs

Handshaked, parametrised instruction fetch unit that replaces the single-cycle PC register/next-PC block. It owns the PC, issues one fetch at a time to instruction memory over a valid/ready request/response pair, and hands `{pc, inst, fault}` to the IDU over a valid/ready channel. It accepts redirects from the EXU at any time and discards any stale fetch. Misaligned redirect targets are flagged as faults without a memory access.

## Interface
- `XLEN`, 32: PC and instruction width.
- `RESET_PC`, 32'h8000_0000: PC after reset.
- `CNT_W`, 32: width of the delivered-instruction counter.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  XLEN  fetch address.
- `imem_rsp_valid`  in  1  response valid.
- `imem_rsp_ready`  out  1  IFU accepts response.
- `imem_rsp_data`  in  XLEN  fetched instruction.
- `imem_rsp_err`  in  1  access error.
- `redirect_valid`  in  1  EXU redirect (branch/jump/JALR).
- `redirect_pc`  in  XLEN  redirect target.
- `out_valid`  out  1  instruction valid to IDU.
- `out_ready`  in  1  IDU accepts.
- `out_pc`  out  XLEN  PC of delivered instruction.
- `out_inst`  out  XLEN  instruction word (0 on fault).
- `out_fault`  out  1  1 = access error or misaligned target.
- `fetch_cnt`  out  CNT_W  count of completed out handshakes, wraps.

## Operation
- Registers: `pc`, `state`, `stale`, `out_inst`, `out_fault`, `fetch_cnt`.
- States:
  - S_REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On req handshake, go to S_WAIT.
  - S_WAIT: `imem_rsp_ready`=1. On `imem_rsp_valid`:
    - if `stale`: discard the response, clear `stale`, go to S_REQ.
    - else: latch data and err into `out_inst`/`out_fault` (`out_inst`=0 if err), go to S_OUT.
  - S_OUT: holds outputs. On out handshake: `pc`←`pc`+4 mod 2^XLEN, `fetch_cnt`+1, go to S_REQ.
- `out_valid` = (state==S_OUT) && !`redirect_valid` (combinational kill). `out_pc`=`pc`.
- Redirect, sampled every cycle, takes priority over all other events:
  - S_REQ, request not accepted: `pc`←`redirect_pc`, stay in S_REQ. Memory samples the address only on handshake, so the address may change while valid is held.
  - S_REQ, request accepted in the same cycle: `pc`←`redirect_pc`, set `stale`, go to S_WAIT.
  - S_WAIT: `pc`←`redirect_pc`, set `stale`. If a response arrives in the same cycle it is discarded, `stale` is cleared, and the FSM goes to S_REQ.
  - S_OUT: the instruction is dropped (no handshake, no count), `pc`←`redirect_pc`, go to S_REQ.
- Misaligned redirect (`redirect_pc[1:0]`≠0): the redirect rules above apply, except the FSM goes to S_OUT with `out_fault`=1 and `out_inst`=0, and no memory request is made. If a request is still outstanding, the FSM enters S_OUT only after the stale response has been drained.
- `fetch_cnt` wraps from all-ones to 0.

## Timing
- Reset (asynchronous assert, synchronous release by `clk`): `pc`=RESET_PC, state=S_REQ, `stale`=0, `out_inst`=0, `out_fault`=0, `fetch_cnt`=0.
- During reset, `imem_req_valid`, `imem_rsp_ready` and `out_valid` are 0. `imem_req_valid` is 1 in the first cycle after release.
- Best case with zero-wait memory: request accepted in cycle n, response in cycle n+1, `out_valid` in cycle n+2, next request in cycle n+3. Throughput is one instruction per 3 cycles.
- At most one request is outstanding.
- No combinational path from `imem_rsp_*` to `out_*`.
- The only combinational input-to-output path is `redirect_valid` → `out_valid`.
- Reset asserted mid-fetch abandons the transaction. Memory must also be reset.

## Test plan
- Reset release, zero-wait memory returning 32'h00000413:
  - request at 0x8000_0000;
  - `out_valid` 2 cycles after the request handshake with `out_pc`=0x8000_0000, `out_inst`=0x00000413;
  - next request at 0x8000_0004; `fetch_cnt`=1.
- Memory stalls `req_ready` 3 cycles, then returns the response 4 cycles later; IDU holds `out_ready`=0 for 5 cycles:
  - `imem_req_addr` stays stable;
  - `out_*` stays stable;
  - exactly one count.
- Redirect to 0x8000_0100 while in S_WAIT:
  - the response for the old PC is discarded and `out_valid` never rises for it;
  - the next request is at 0x8000_0100.
- Redirect asserted in S_OUT together with `out_ready`=1:
  - `out_valid`=0 that cycle and `fetch_cnt` is unchanged;
  - the next request is at `redirect_pc`.
- Redirect to 0x8000_0102:
  - no request is issued;
  - `out_valid` with `out_pc`=0x8000_0102, `out_fault`=1, `out_inst`=0.
- Response with `imem_rsp_err`=1 → `out_fault`=1, `out_inst`=0. Separately, preload `fetch_cnt` near wrap with CNT_W=4: after 16 deliveries it reads 0.
